// File: rtl/seven_seg_mux_ctrl_if.sv
// Signal bundle between display-data logic (master) and seven_seg_mux_ctrl (slave).
// The brightness input exists only when SEVEN_SEG_BRIGHTNESS_EN is defined.
interface seven_seg_mux_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              segment;
  logic                    dp_n;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0]              brightness;

  modport master (
    output enable, digits, dp, digit_en, brightness,
    input  anode, segment, dp_n, digit_idx, frame_done
  );
  modport slave (
    input  enable, digits, dp, digit_en, brightness,
    output anode, segment, dp_n, digit_idx, frame_done
  );
`else
  modport master (
    output enable, digits, dp, digit_en,
    input  anode, segment, dp_n, digit_idx, frame_done
  );
  modport slave (
    input  enable, digits, dp, digit_en,
    output anode, segment, dp_n, digit_idx, frame_done
  );
`endif
endinterface

// File: rtl/seven_seg_mux_ctrl.sv
// N-digit multiplexed seven-segment controller with per-frame data snapshot and blank gaps.
// Optional feature macro: SEVEN_SEG_BRIGHTNESS_EN (adds a 4-bit brightness duty control).
module seven_seg_mux_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input logic                 div_clock,
  input logic                 reset,
  seven_seg_mux_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_T = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic                    fdone_q, fdone_d;
  logic                    capture;
  logic                    lit;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0]              snap_br_q, snap_br_d;
  logic [31:0]             lit_lim;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Next-state: slot sequencing and snapshot capture at frame boundaries
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    fdone_d    = 1'b0;
    capture    = 1'b0;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    snap_br_d  = snap_br_q;
`endif
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          capture = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (BLANK_TICKS > 0) ? BLANK : SHOW;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            state_d = (BLANK_TICKS > 0) ? BLANK : SHOW;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              fdone_d = 1'b1;
              capture = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
    if (capture) begin
      snap_dig_d = bus.digits;
      snap_dp_d  = bus.dp;
      snap_en_d  = bus.digit_en;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
      snap_br_d  = bus.brightness;
`endif
    end
  end

  // Outputs are derived from next-state so they register on the same edge as the FSM
  always_comb begin
    anode_d = '1;
    seg_d   = 7'h7F;
    dp_n_d  = 1'b1;
    lit     = 1'b1;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    lit_lim = ((32'(snap_br_d) + 32'd1) * 32'(DWELL_TICKS)) >> 4;
    lit     = (32'(cnt_d) < lit_lim);
`endif
    if (state_d == SHOW) begin
      seg_d          = hex7(snap_dig_d[{idx_d, 2'b00} +: 4]);
      dp_n_d         = ~snap_dp_d[idx_d];
      anode_d[idx_d] = ~(snap_en_d[idx_d] & lit);
    end
  end

  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_en_q  <= '0;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
      snap_br_q  <= '0;
`endif
      anode_q    <= '1;
      seg_q      <= 7'h7F;
      dp_n_q     <= 1'b1;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_en_q  <= snap_en_d;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
      snap_br_q  <= snap_br_d;
`endif
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      dp_n_q     <= dp_n_d;
      fdone_q    <= fdone_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.segment    = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = fdone_q;
endmodule
